// File: rtl/mdu_pkg.sv
// mdu_pkg: op-code constants, default latencies, FSM state encoding and
// op-class predicates for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Multiply-class ops use the multiply latency; accumulate ops belong
    // here only when the accumulate datapath is built.
    function automatic logic is_mult(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result generator for every multi-cycle op.
// Divide-by-zero, signed overflow and (with MDU_MADD_EN) accumulate rules
// are resolved here so the top only has to latch the result.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             sgn;
    logic [W2-1:0]    a_ext, b_ext, prod;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign sgn   = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    assign a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend.
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
    logic [W2-1:0] acc;
    assign acc = {hi, lo};
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};
`endif

    // Select the 2*WIDTH {HI,LO} result for the requested op.
    always_comb begin
        result = prod;
        case (op)
            OP_DIV, OP_DIVU: begin
                if (b == '0)
                    result = {a, {WIDTH{1'b1}}};
                else if ((op == OP_DIV) && (a == INT_MIN) && (b == {WIDTH{1'b1}}))
                    result = {{WIDTH{1'b0}}, a};
                else
                    result = {rem, quot};
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: result = acc + prod;
            OP_MSUB, OP_MSUBU: result = acc - prod;
`endif
            default: result = prod;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at issue, held in a pending register for the class
// latency, then committed to HI/LO with a one-cycle done pulse.
// Optional feature macro: MDU_MADD_EN (accumulate ops 6-9).
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] pending_reg, pending_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;
    logic [2*WIDTH-1:0] calc_result;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (bus.op),
        .a      (bus.A),
        .b      (bus.B),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .result (calc_result)
    );

    // Next-state logic: issue in IDLE, count down and commit in RUN.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mult(bus.op)) begin
                        pending_next = calc_result;
                        cnt_next     = CW'(MULT_CYCLES);
                        state_next   = ST_RUN;
                    end else if (is_div(bus.op)) begin
                        pending_next = calc_result;
                        cnt_next     = CW'(DIV_CYCLES);
                        state_next   = ST_RUN;
                    end else if (is_mt(bus.op)) begin
                        if (bus.op == OP_MTHI)
                            hi_next = bus.A;
                        else
                            lo_next = bus.A;
                    end
                end
            end
            ST_RUN: begin
                // New starts are ignored here; the core is stalled on busy.
                if (cnt_reg == CW'(1)) begin
                    {hi_next, lo_next} = pending_reg;
                    cnt_next           = '0;
                    state_next         = ST_IDLE;
                    done_next          = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            pending_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
        end
    end

    assign bus.busy = (state_reg == ST_RUN);
    assign bus.done = done_reg;
    assign bus.HI   = hi_reg;
    assign bus.LO   = lo_reg;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in the execute stage of the next-generation (pipelined) CPU. Accepts one operation per handshake, holds `busy` for a parameterised latency, then commits the 2×WIDTH result to HI/LO. The core stalls any HI/LO access while `busy` is high. Width and per-class latencies are parameters.

## Interface
- `WIDTH`, 32, operand and HI/LO width
- `MULT_CYCLES`, 5, busy cycles for multiply-class ops (≥1)
- `DIV_CYCLES`, 10, busy cycles for divide-class ops (≥1)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge clears all state
- `start`  in  1  launch `op` this cycle
- `op`  in  4  operation code (see package)
- `A`  in  WIDTH  rs operand / MTHI/MTLO data
- `B`  in  WIDTH  rt operand
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse in the first cycle HI/LO hold a new multi-cycle result
- `HI`  out  WIDTH  HI register
- `LO`  out  WIDTH  LO register

## Operation
- Op codes: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; other codes are NOPs.
- States: IDLE, RUN. In IDLE, `start` with a valid multi-cycle op captures the computed result into a 2×WIDTH pending register, loads the counter with the class latency, and enters RUN.
- RUN: counter decrements each cycle. At the edge where counter==1: {HI,LO}←pending, return to IDLE, `done`=1 in the following cycle.
- `start` during RUN is ignored (no queueing); the core must not issue.
- MTHI/MTLO in IDLE: write HI/LO at that edge, no busy, no `done`.
- Multiply: {HI,LO} = A×B, signed (MULT) or unsigned (MULTU).
- Divide: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- B==0: HI←A, LO←all ones (both DIV and DIVU), normal latency.
- DIV with A = −2^(WIDTH−1), B = −1: LO←A, HI←0.
- MADD/MSUB: {HI,LO} ± signed/unsigned A×B (mod 2^(2·WIDTH)), computed from HI/LO as they stand at issue, MULT latency.
- Reset values: `busy`=0, `done`=0, HI=0, LO=0, state IDLE, counter 0.

## Timing
- `start` sampled at edge N → `busy`=1 from cycle N+1 for LAT cycles; HI/LO valid and `busy`=0 from N+LAT+1; `done`=1 in N+LAT+1 only.
- `busy` is registered; the core stalls on `busy | (start & multi-cycle op)`.
- Back-to-back: a new `start` is accepted in the cycle `busy` falls (N+LAT+1).
- `reset` low mid-RUN aborts: pending result discarded, HI/LO cleared, `busy`/`done` low next cycle.
- `reset` low and `start` in the same cycle: reset wins.

## Configuration
- `MDU_MADD_EN` defined: op codes 6–9 execute as above.
- Undefined: op codes 6–9 are NOPs (no busy, HI/LO unchanged); accumulate datapath not synthesised.

## Structure
- Package `mdu_pkg`: op-code constants, default latency constants, state encoding, and the `is_mult`/`is_div`/`is_mt` class predicates.
- Sub-module `mdu_calc`: purely combinational; takes op, A, B, HI, LO and produces the 2×WIDTH result, including the divide-by-zero, overflow, and accumulate rules.
- `mdu` holds the FSM, counter, pending register, and HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=7 → `busy` for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulse once.
- MULTU A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=−7, B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV A=0x80000000, B=−1 → LO=0x80000000, HI=0.
- DIVU A=5, B=0 → HI=5, LO=0xFFFFFFFF. `start` of MULT issued mid-busy → ignored, HI/LO unchanged by it.
- MTLO 10, MTHI 0, then MADD 3×4 (with `MDU_MADD_EN`) → LO=22, HI=0. Without the macro → LO=10, `busy` never asserted.
- DIV started, `reset` driven low in busy cycle 4 → next cycle `busy`=0, HI=LO=0, no `done`.
